// File: rtl/draw_cmd_queue.sv
// draw_cmd_queue: command FIFO and frame sequencer in front of the draw engine.
// Each accepted frame_start issues one full-screen clear and then drains exactly
// the commands that were queued when the frame was accepted, one per engine
// draw_en/draw_done handshake. Commands pushed later wait for the next frame.
module draw_cmd_queue #(
    parameter int                  COORD_W      = 16,
    parameter int                  COLOUR_W     = 32,
    parameter int                  DEPTH        = 16,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
    input  logic                    sys_clk,
    input  logic                    reset,

    input  logic                    frame_start,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [3:0]              cmd_opcode,
    input  logic [COORD_W-1:0]      cmd_ax,
    input  logic [COORD_W-1:0]      cmd_ay,
    input  logic [COORD_W-1:0]      cmd_bx,
    input  logic [COORD_W-1:0]      cmd_by,
    input  logic [COORD_W-1:0]      cmd_cx,
    input  logic [COORD_W-1:0]      cmd_cy,
    input  logic [COLOUR_W-1:0]     cmd_colour,

    output logic [3:0]              opcode,
    output logic [COORD_W-1:0]      ax,
    output logic [COORD_W-1:0]      ay,
    output logic [COORD_W-1:0]      bx,
    output logic [COORD_W-1:0]      by,
    output logic [COORD_W-1:0]      cx,
    output logic [COORD_W-1:0]      cy,
    output logic [COLOUR_W-1:0]     colour,
    output logic                    draw_en,
    input  logic                    draw_done,

    output logic [$clog2(DEPTH):0]  level,
    output logic                    frame_busy,
    output logic                    frame_done,
    output logic                    frame_missed
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int ENTRY_W = 4 + 6 * COORD_W + COLOUR_W;

    localparam logic [PTR_W-1:0] FULL_LEVEL = PTR_W'(DEPTH);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_CLEAR_START = 3'd1;
    localparam logic [2:0] S_CLEAR_WAIT  = 3'd2;
    localparam logic [2:0] S_CMD_CHECK   = 3'd3;
    localparam logic [2:0] S_CMD_START   = 3'd4;
    localparam logic [2:0] S_CMD_WAIT    = 3'd5;
    localparam logic [2:0] S_DONE        = 3'd6;

    logic [2:0]         state;
    logic [PTR_W-1:0]   remaining;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [ENTRY_W-1:0] wr_entry;

    logic [3:0]         head_opcode;
    logic [COORD_W-1:0] head_ax;
    logic [COORD_W-1:0] head_ay;
    logic [COORD_W-1:0] head_bx;
    logic [COORD_W-1:0] head_by;
    logic [COORD_W-1:0] head_cx;
    logic [COORD_W-1:0] head_cy;
    logic [COLOUR_W-1:0] head_colour;

    logic push;
    logic pop;
    logic accept_frame;
    logic finish_frame;
    logic wait_done;

    // Slot availability comes straight from the registered occupancy count.
    assign cmd_ready = (level != FULL_LEVEL);

    assign push = cmd_valid && cmd_ready;
    assign pop  = (state == S_CMD_START);

    assign accept_frame = (state == S_IDLE) && frame_start;
    assign finish_frame = (state == S_CMD_CHECK) && (remaining == '0);

    // A done pulse coinciding with our own start pulse belongs to nothing we issued.
    assign wait_done = draw_done && !draw_en;

    assign wr_entry = {cmd_opcode, cmd_ax, cmd_ay, cmd_bx, cmd_by,
                       cmd_cx, cmd_cy, cmd_colour};

    assign {head_opcode, head_ax, head_ay, head_bx, head_by,
            head_cx, head_cy, head_colour} = mem[rptr[IDX_W-1:0]];

    // Pointers wrap modulo 2*DEPTH; level tracks wptr - rptr and holds on push+pop.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Command storage; contents need no reset because level guards every read.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wptr[IDX_W-1:0]] <= wr_entry;
        end
    end

    // Frame sequencer: clear first, then exactly the snapshot count of commands.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        remaining <= level;
                        state     <= S_CLEAR_START;
                    end
                end
                S_CLEAR_START: begin
                    state <= S_CLEAR_WAIT;
                end
                S_CLEAR_WAIT: begin
                    if (wait_done) begin
                        state <= S_CMD_CHECK;
                    end
                end
                S_CMD_CHECK: begin
                    if (remaining == '0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_CMD_START;
                    end
                end
                S_CMD_START: begin
                    remaining <= remaining - 1'b1;
                    state     <= S_CMD_WAIT;
                end
                S_CMD_WAIT: begin
                    if (wait_done) begin
                        state <= S_CMD_CHECK;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Frame status: busy spans acceptance to completion, done pulses with the S_DONE cycle.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            frame_missed <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept_frame) begin
                frame_busy <= 1'b1;
            end
            if (finish_frame) begin
                frame_busy <= 1'b0;
                frame_done <= 1'b1;
            end
            if (frame_start && (state != S_IDLE)) begin
                frame_missed <= 1'b1;
            end
        end
    end

    // Engine operands load only in the START states and hold until the next load.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            draw_en <= 1'b0;
            opcode  <= 4'd0;
            ax      <= '0;
            ay      <= '0;
            bx      <= '0;
            by      <= '0;
            cx      <= '0;
            cy      <= '0;
            colour  <= '0;
        end else begin
            draw_en <= 1'b0;
            if (state == S_CLEAR_START) begin
                draw_en <= 1'b1;
                opcode  <= 4'd0;
                ax      <= '0;
                ay      <= '0;
                bx      <= '0;
                by      <= '0;
                cx      <= '0;
                cy      <= '0;
                colour  <= CLEAR_COLOUR;
            end else if (state == S_CMD_START) begin
                draw_en <= 1'b1;
                opcode  <= head_opcode;
                ax      <= head_ax;
                ay      <= head_ay;
                bx      <= head_bx;
                by      <= head_by;
                cx      <= head_cx;
                cy      <= head_cy;
                colour  <= head_colour;
            end
        end
    end

endmodule

// File: tb/tb_draw_cmd_queue.sv
// Directed bench for draw_cmd_queue: a fixed-latency engine model answers every
// draw_en, every issued draw is logged, and a queue of pushed commands gives
// the order and contents each frame must draw.
module tb_draw_cmd_queue;

    localparam int COORD_W  = 16;
    localparam int COLOUR_W = 32;
    localparam int DEPTH    = 16;
    localparam int ENG_LAT  = 10;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] ax;
        logic [31:0] col;
    } cmd_rec_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] ax;
        logic [15:0] ay;
        logic [15:0] bx;
        logic [15:0] by;
        logic [15:0] cx;
        logic [15:0] cy;
        logic [31:0] col;
        int          cyc;
    } draw_rec_t;

    logic                sys_clk = 1'b0;
    logic                reset = 1'b1;
    logic                frame_start = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [3:0]          cmd_opcode = '0;
    logic [COORD_W-1:0]  cmd_ax = '0;
    logic [COORD_W-1:0]  cmd_ay = '0;
    logic [COORD_W-1:0]  cmd_bx = '0;
    logic [COORD_W-1:0]  cmd_by = '0;
    logic [COORD_W-1:0]  cmd_cx = '0;
    logic [COORD_W-1:0]  cmd_cy = '0;
    logic [COLOUR_W-1:0] cmd_colour = '0;
    logic [3:0]          opcode;
    logic [COORD_W-1:0]  ax;
    logic [COORD_W-1:0]  ay;
    logic [COORD_W-1:0]  bx;
    logic [COORD_W-1:0]  by;
    logic [COORD_W-1:0]  cx;
    logic [COORD_W-1:0]  cy;
    logic [COLOUR_W-1:0] colour;
    logic                draw_en;
    logic                draw_done = 1'b0;
    logic [4:0]          level;
    logic                frame_busy;
    logic                frame_done;
    logic                frame_missed;

    int        check_cnt = 0;
    int        pass_cnt = 0;
    int        cyc = 0;

    cmd_rec_t  exp_q[$];
    draw_rec_t log_q[$];
    draw_rec_t mon_rec;

    int        eng_cnt = 0;
    logic      eng_busy = 1'b0;
    logic      eng_spurious = 1'b0;
    logic      prev_en = 1'b0;
    int        en_double = 0;
    int        last_done_cyc = -1;
    int        fd_count = 0;
    int        fd_cyc = -1;
    logic [4:0] fd_level = '0;
    logic      fd_busy = 1'b0;
    int        fs_cyc = 0;

    draw_cmd_queue #(
        .COORD_W(COORD_W),
        .COLOUR_W(COLOUR_W),
        .DEPTH(DEPTH),
        .CLEAR_COLOUR(32'h0)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .frame_start(frame_start),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_ax(cmd_ax),
        .cmd_ay(cmd_ay),
        .cmd_bx(cmd_bx),
        .cmd_by(cmd_by),
        .cmd_cx(cmd_cx),
        .cmd_cy(cmd_cy),
        .cmd_colour(cmd_colour),
        .opcode(opcode),
        .ax(ax),
        .ay(ay),
        .bx(bx),
        .by(by),
        .cx(cx),
        .cy(cy),
        .colour(colour),
        .draw_en(draw_en),
        .draw_done(draw_done),
        .level(level),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .frame_missed(frame_missed)
    );

    // Free-running clock.
    always #5 sys_clk = ~sys_clk;

    // Cycle index; cycle k lasts from the posedge that sets cyc=k to the next posedge.
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Engine model and monitor, sampled mid-cycle on the falling edge.
    always @(negedge sys_clk) begin
        draw_done = 1'b0;
        if (reset) begin
            eng_busy = 1'b0;
            eng_cnt  = 0;
            prev_en  = 1'b0;
        end else begin
            if (draw_en) begin
                mon_rec.op  = opcode;
                mon_rec.ax  = ax;
                mon_rec.ay  = ay;
                mon_rec.bx  = bx;
                mon_rec.by  = by;
                mon_rec.cx  = cx;
                mon_rec.cy  = cy;
                mon_rec.col = colour;
                mon_rec.cyc = cyc;
                log_q.push_back(mon_rec);
                if (prev_en) en_double++;
                eng_busy = 1'b1;
                eng_cnt  = ENG_LAT;
                if (eng_spurious) draw_done = 1'b1;
            end else if (eng_busy) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    draw_done     = 1'b1;
                    eng_busy      = 1'b0;
                    last_done_cyc = cyc;
                end
            end
            prev_en = draw_en;
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc   = cyc;
            fd_level = level;
            fd_busy  = frame_busy;
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, pass=%0d checks=%0d", pass_cnt, check_cnt);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic setCmd(input logic [3:0] op, input logic [15:0] a, input logic [31:0] col);
        cmd_opcode = op;
        cmd_ax     = a;
        cmd_ay     = a ^ 16'h5a5a;
        cmd_bx     = a + 16'd1;
        cmd_by     = a + 16'd2;
        cmd_cx     = a + 16'd4;
        cmd_cy     = a + 16'd3;
        cmd_colour = col;
    endtask

    // Push one command, waiting (bounded) for a free slot, and record it in the model.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [31:0] col);
        int       n;
        cmd_rec_t e;
        n = 0;
        setCmd(op, a, col);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        checkOutput("push accepted", cmd_ready, 1);
        if (cmd_ready) begin
            tick();
            e.op  = op;
            e.ax  = a;
            e.col = col;
            exp_q.push_back(e);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic startFrame();
        frame_start = 1'b1;
        fs_cyc      = cyc;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic waitFrameDone(input int start_cnt);
        int n;
        n = 0;
        while (fd_count == start_cnt && n < 3000) begin
            tick();
            n++;
        end
        checkOutput("frame completes", fd_count, start_cnt + 1);
    endtask

    // Compare the logged draws of one frame: a clear, then ncmd queued commands in order.
    task automatic checkFrameLog(input int ncmd);
        draw_rec_t r;
        cmd_rec_t  e;
        checkOutput("draw_en count", log_q.size(), ncmd + 1);
        if (log_q.size() > 0) begin
            r = log_q[0];
            checkOutput("clear opcode", r.op, 0);
            checkOutput("clear colour", r.col, 0);
            checkOutput("clear coords abc", {r.ax, r.ay, r.bx, r.by}, 0);
            checkOutput("clear coords c", {r.cx, r.cy}, 0);
            checkOutput("clear draw_en timing", r.cyc, fs_cyc + 2);
        end
        for (int i = 1; i < log_q.size() && i <= ncmd; i++) begin
            if (exp_q.size() == 0) break;
            r = log_q[i];
            e = exp_q.pop_front();
            checkOutput($sformatf("cmd%0d ax", i), r.ax, e.ax);
            checkOutput($sformatf("cmd%0d opcode", i), r.op, e.op);
            checkOutput($sformatf("cmd%0d colour", i), r.col, e.col);
            checkOutput($sformatf("cmd%0d ay/bx/by", i), {r.ay, r.bx, r.by},
                        {e.ax ^ 16'h5a5a, e.ax + 16'd1, e.ax + 16'd2});
            checkOutput($sformatf("cmd%0d cx/cy", i), {r.cx, r.cy}, {e.ax + 16'd4, e.ax + 16'd3});
        end
        checkOutput("frame_done two cycles after last draw_done", fd_cyc, last_done_cyc + 2);
        checkOutput("frame_busy low with frame_done", fd_busy, 0);
        log_q.delete();
    endtask

    initial begin
        int       fcnt;
        int       n;
        int       acc_cyc;
        int       logsz;
        int       ncmd;
        cmd_rec_t e;

        // ---------------- reset state ----------------
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        checkOutput("reset draw_en", draw_en, 0);
        checkOutput("reset opcode", opcode, 0);
        checkOutput("reset coords", {ax, ay, bx, by}, 0);
        checkOutput("reset coords c", {cx, cy}, 0);
        checkOutput("reset colour", colour, 0);
        checkOutput("reset level", level, 0);
        checkOutput("reset frame_busy", frame_busy, 0);
        checkOutput("reset frame_done", frame_done, 0);
        checkOutput("reset frame_missed", frame_missed, 0);
        checkOutput("reset cmd_ready", cmd_ready, 1);
        tick();

        // ---------------- three commands, one frame ----------------
        $display("[TB] three-command frame");
        for (int i = 1; i <= 3; i++) applyStimulus(4'h1, 16'(i), 32'hFFFF0000);
        checkOutput("level after 3 pushes", level, 3);
        fcnt = fd_count;
        startFrame();
        checkOutput("frame_busy at T+1", frame_busy, 1);
        checkOutput("no draw_en at T+1", draw_en, 0);
        tick();
        checkOutput("draw_en at T+2", draw_en, 1);
        waitFrameDone(fcnt);
        checkFrameLog(3);
        checkOutput("level after frame", level, 0);
        checkOutput("operand ax holds last", ax, 3);
        checkOutput("operand colour holds last", colour, 32'hFFFF0000);

        // ---------------- full FIFO and held push ----------------
        $display("[TB] full FIFO");
        for (int i = 0; i < DEPTH; i++) applyStimulus(4'h2, 16'(100 + i), 32'h00FF00FF);
        checkOutput("level full", level, 16);
        checkOutput("cmd_ready when full", cmd_ready, 0);
        setCmd(4'h3, 16'd200, 32'h12345678);
        cmd_valid = 1'b1;
        ticks(3);
        checkOutput("level held at full", level, 16);
        checkOutput("cmd_ready still low", cmd_ready, 0);
        fcnt    = fd_count;
        acc_cyc = -1;
        startFrame();
        n = 0;
        while (fd_count == fcnt && n < 3000) begin
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc;
                tick();
                cmd_valid = 1'b0;
                e.op  = 4'h3;
                e.ax  = 16'd200;
                e.col = 32'h12345678;
                exp_q.push_back(e);
            end else begin
                tick();
            end
            n++;
        end
        cmd_valid = 1'b0;
        checkOutput("frame completes (full)", fd_count, fcnt + 1);
        if (log_q.size() > 1) begin
            checkOutput("held push accepted with first pop", acc_cyc, log_q[1].cyc);
        end
        checkFrameLog(16);
        checkOutput("level at frame_done", fd_level, 1);
        fcnt = fd_count;
        startFrame();
        waitFrameDone(fcnt);
        checkFrameLog(1);
        checkOutput("level drained", level, 0);

        // ---------------- empty queue, spurious done during draw_en ----------------
        $display("[TB] empty frame");
        eng_spurious = 1'b1;
        fcnt = fd_count;
        startFrame();
        waitFrameDone(fcnt);
        checkFrameLog(0);
        eng_spurious = 1'b0;

        // ---------------- frame_start while busy ----------------
        $display("[TB] missed frame_start");
        applyStimulus(4'h5, 16'd300, 32'hA0A0A0A0);
        applyStimulus(4'h0, 16'd301, 32'hB0B0B0B0);
        checkOutput("frame_missed clear before", frame_missed, 0);
        fcnt = fd_count;
        startFrame();
        n = 0;
        while (log_q.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("first command issued", log_q.size(), 2);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checkOutput("frame_missed set", frame_missed, 1);
        waitFrameDone(fcnt);
        checkFrameLog(2);
        ticks(20);
        checkOutput("no extra frame", fd_count, fcnt + 1);
        checkOutput("no extra draws", log_q.size(), 0);
        checkOutput("idle after frame", frame_busy, 0);
        checkOutput("frame_missed sticky", frame_missed, 1);
        fcnt = fd_count;
        startFrame();
        waitFrameDone(fcnt);
        checkFrameLog(0);
        checkOutput("frame_missed still sticky", frame_missed, 1);

        // ---------------- push and pop in one cycle at level 5 ----------------
        $display("[TB] simultaneous push/pop");
        for (int i = 0; i < 5; i++) applyStimulus(4'h6, 16'(400 + i), 32'h0000FFFF);
        fcnt = fd_count;
        startFrame();
        ticks(13);
        checkOutput("level before push/pop", level, 5);
        setCmd(4'h7, 16'd77, 32'h77777777);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        e.op  = 4'h7;
        e.ax  = 16'd77;
        e.col = 32'h77777777;
        exp_q.push_back(e);
        checkOutput("level after push/pop", level, 5);
        checkOutput("pop issued draw_en", draw_en, 1);
        waitFrameDone(fcnt);
        checkFrameLog(5);
        checkOutput("level at frame_done (push/pop)", fd_level, 1);

        // ---------------- order across pointer wrap ----------------
        $display("[TB] wrap order");
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 10; k++) begin
                applyStimulus(4'(k), 16'(1000 + 10 * f + k), 32'hC0000000 | 32'(10 * f + k));
            end
            ncmd = exp_q.size();
            fcnt = fd_count;
            startFrame();
            waitFrameDone(fcnt);
            checkFrameLog(ncmd);
        end
        checkOutput("level after wrap frames", level, 0);

        // ---------------- reset mid-frame ----------------
        $display("[TB] reset in CMD_WAIT");
        for (int i = 0; i < 4; i++) applyStimulus(4'h9, 16'(500 + i), 32'h99999999);
        fcnt = fd_count;
        startFrame();
        n = 0;
        while (log_q.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        ticks(2);
        logsz = log_q.size();
        reset = 1'b1;
        tick();
        checkOutput("reset level", level, 0);
        checkOutput("reset draw_en mid-frame", draw_en, 0);
        checkOutput("reset frame_busy mid-frame", frame_busy, 0);
        checkOutput("reset frame_done mid-frame", frame_done, 0);
        checkOutput("reset cmd_ready mid-frame", cmd_ready, 1);
        reset = 1'b0;
        exp_q.delete();
        ticks(40);
        checkOutput("no frame_done after reset", fd_count, fcnt);
        checkOutput("no draw_en after reset", log_q.size(), logsz);
        checkOutput("idle after reset", frame_busy, 0);

        checkOutput("draw_en single-cycle", en_double, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
